// File: rtl/blob_width_serializer.sv
// Wide-to-narrow blob serializer: buffers DIN_W-bit words in a small FIFO and
// emits them as RATIO narrow lanes, lane 0 first, carrying the blob eop mark.
module blob_width_serializer #(
    parameter int DIN_W  = 256,
    parameter int DOUT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              blob_din_rdy,
    input  logic              blob_din_en,
    input  logic [DIN_W-1:0]  blob_din,
    input  logic              blob_din_eop,
    input  logic              blob_dout_rdy,
    output logic              blob_dout_en,
    output logic [DOUT_W-1:0] blob_dout,
    output logic              blob_dout_eop,
    output logic              err_ovf
);

    localparam int RATIO  = DIN_W / DOUT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Buffer payload is never reset; only the occupancy bookkeeping is.
    logic [RATIO-1:0][DOUT_W-1:0] buf_data [DEPTH];
    logic                         buf_eop  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [LANE_W-1:0] lane_cnt;
    logic              lane_last;
    logic              not_empty;
    logic              push;
    logic              pop;

    assign not_empty = (count != '0);
    assign lane_last = (lane_cnt == LANE_W'(RATIO - 1));
    assign push      = blob_din_en & blob_din_rdy;
    assign pop       = blob_dout_en & lane_last;

    // Outputs come from the head slot and lane counter; only the strobe sees blob_dout_rdy.
    assign blob_dout_en  = not_empty & blob_dout_rdy;
    assign blob_dout     = buf_data[rd_ptr][lane_cnt];
    assign blob_dout_eop = not_empty & lane_last & buf_eop[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= blob_din;
            buf_eop[wr_ptr]  <= blob_din_eop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lane_cnt     <= '0;
            err_ovf      <= 1'b0;
            blob_din_rdy <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (blob_dout_en) begin
                lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
            end
            count        <= count_next;
            // Ready is a registered view of post-edge occupancy, so it never tracks blob_din_en.
            blob_din_rdy <= (count_next < CNT_W'(DEPTH));
            if (blob_din_en && !blob_din_rdy) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blob_width_serializer.sv
// Directed bench for blob_width_serializer with the default 256->32 geometry.
module tb_blob_width_serializer;

    logic         clk;
    logic         rst;
    logic         blob_din_rdy;
    logic         blob_din_en;
    logic [255:0] blob_din;
    logic         blob_din_eop;
    logic         blob_dout_rdy;
    logic         blob_dout_en;
    logic [31:0]  blob_dout;
    logic         blob_dout_eop;
    logic         err_ovf;

    int n_checks;
    int n_fail;

    blob_width_serializer #(.DIN_W(256), .DOUT_W(32), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .blob_din_rdy  (blob_din_rdy),
        .blob_din_en   (blob_din_en),
        .blob_din      (blob_din),
        .blob_din_eop  (blob_din_eop),
        .blob_dout_rdy (blob_dout_rdy),
        .blob_dout_en  (blob_dout_en),
        .blob_dout     (blob_dout),
        .blob_dout_eop (blob_dout_eop),
        .err_ovf       (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wide word whose lane k holds base+k.
    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = base + 32'(k);
        end
        return w;
    endfunction

    initial begin
        int idx;
        int n_words;
        int eop_cnt;
        int eop_pos;
        logic [31:0] exp_w;

        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        blob_din_en   = 1'b0;
        blob_din      = '0;
        blob_din_eop  = 1'b0;
        blob_dout_rdy = 1'b1;

        // Reset state, then first cycle out of reset.
        @(negedge clk); #1;
        check_val("rst_din_rdy", 32'(blob_din_rdy), 32'd0);
        check_val("rst_dout_en", 32'(blob_dout_en), 32'd0);
        check_val("rst_eop", 32'(blob_dout_eop), 32'd0);
        check_val("rst_err", 32'(err_ovf), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        check_val("post_rst_din_rdy", 32'(blob_din_rdy), 32'd1);
        check_val("post_rst_dout_en", 32'(blob_dout_en), 32'd0);
        check_val("post_rst_eop", 32'(blob_dout_eop), 32'd0);
        check_val("post_rst_err", 32'(err_ovf), 32'd0);

        // Single eop word: lanes 0..7 in the eight cycles after the push.
        @(negedge clk);
        blob_din_en = 1'b1; blob_din = mk(32'h0); blob_din_eop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); blob_din_en = 1'b0; blob_din_eop = 1'b0; #1;
            check_val("single_en", 32'(blob_dout_en), 32'd1);
            check_val("single_dat", blob_dout, 32'(k));
            check_val("single_eop", 32'(blob_dout_eop), 32'(k == 7));
        end
        @(negedge clk); #1;
        check_val("single_idle_en", 32'(blob_dout_en), 32'd0);
        check_val("single_idle_eop", 32'(blob_dout_eop), 32'd0);

        // Fill with downstream stalled, then one overflow attempt.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            blob_dout_rdy = 1'b0;
            blob_din_en   = 1'b1;
            blob_din      = mk(32'h100 + 32'(i * 16));
            blob_din_eop  = (i == 3);
            #1;
            check_val("fill_din_rdy", 32'(blob_din_rdy), 32'd1);
        end
        @(negedge clk);
        blob_din_en = 1'b1; blob_din = mk(32'hDEAD0000); blob_din_eop = 1'b0; #1;
        check_val("full_din_rdy", 32'(blob_din_rdy), 32'd0);
        check_val("full_err_before", 32'(err_ovf), 32'd0);
        @(negedge clk); blob_din_en = 1'b0; #1;
        check_val("ovf_err", 32'(err_ovf), 32'd1);
        check_val("ovf_din_rdy", 32'(blob_din_rdy), 32'd0);
        check_val("ovf_head_dat", blob_dout, 32'h100);
        check_val("ovf_dout_en", 32'(blob_dout_en), 32'd0);

        // Drain with ready toggling; ready returns the cycle after the first pop.
        idx = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            blob_dout_rdy = ((c % 2) == 0);
            #1;
            check_val("drain_din_rdy", 32'(blob_din_rdy), 32'(c >= 15));
            if ((c % 2) == 0) begin
                exp_w = 32'h100 + 32'((idx / 8) * 16 + (idx % 8));
                check_val("drain_en", 32'(blob_dout_en), 32'd1);
                check_val("drain_dat", blob_dout, exp_w);
                check_val("drain_eop", 32'(blob_dout_eop), 32'(idx == 31));
                idx++;
            end else begin
                check_val("drain_stall_en", 32'(blob_dout_en), 32'd0);
            end
        end
        check_val("drain_words", 32'(idx), 32'd32);
        @(negedge clk); blob_dout_rdy = 1'b1; #1;
        check_val("drain_empty_en", 32'(blob_dout_en), 32'd0);
        check_val("err_sticky", 32'(err_ovf), 32'd1);

        // Reset clears the sticky overflow flag.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check_val("clr_err", 32'(err_ovf), 32'd0);
        check_val("clr_din_rdy0", 32'(blob_din_rdy), 32'd0);
        @(negedge clk); #1;
        check_val("clr_din_rdy1", 32'(blob_din_rdy), 32'd1);

        // A push every 8 cycles keeps the output busy without gaps.
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            blob_din_en  = ((c % 8) == 0) && (c < 32);
            blob_din     = mk(32'h200 + 32'((c / 8) * 16));
            blob_din_eop = (c == 24);
            #1;
            check_val("steady_din_rdy", 32'(blob_din_rdy), 32'd1);
            if (c >= 1 && c <= 32) begin
                idx   = c - 1;
                exp_w = 32'h200 + 32'((idx / 8) * 16 + (idx % 8));
                check_val("steady_en", 32'(blob_dout_en), 32'd1);
                check_val("steady_dat", blob_dout, exp_w);
                check_val("steady_eop", 32'(blob_dout_eop), 32'(idx == 31));
            end else if (c == 33) begin
                check_val("steady_idle_en", 32'(blob_dout_en), 32'd0);
            end
        end
        blob_din_en = 1'b0; blob_din_eop = 1'b0;

        // Reset in the middle of an eop word discards it without an eop.
        @(negedge clk);
        blob_din_en = 1'b1; blob_din = mk(32'h300); blob_din_eop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); blob_din_en = 1'b0; blob_din_eop = 1'b0; #1;
            check_val("abort_dat", blob_dout, 32'h300 + 32'(k));
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check_val("abort_en", 32'(blob_dout_en), 32'd0);
        check_val("abort_din_rdy0", 32'(blob_din_rdy), 32'd0);
        check_val("abort_eop", 32'(blob_dout_eop), 32'd0);
        @(negedge clk); #1;
        check_val("abort_din_rdy1", 32'(blob_din_rdy), 32'd1);
        eop_cnt = 0;
        n_words = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (blob_dout_eop) eop_cnt++;
            if (blob_dout_en) n_words++;
        end
        check_val("abort_no_eop", 32'(eop_cnt), 32'd0);
        check_val("abort_no_words", 32'(n_words), 32'd0);

        // Three-word blob: exactly one eop, on narrow word 24.
        n_words = 0;
        eop_cnt = 0;
        eop_pos = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            blob_din_en  = (c < 3);
            blob_din     = mk(32'h400 + 32'(c * 16));
            blob_din_eop = (c == 2);
            #1;
            if (blob_dout_en) begin
                exp_w = 32'h400 + 32'((n_words / 8) * 16 + (n_words % 8));
                check_val("blob3_dat", blob_dout, exp_w);
                n_words++;
                if (blob_dout_eop) begin
                    eop_cnt++;
                    eop_pos = n_words;
                end
            end
        end
        blob_din_en = 1'b0; blob_din_eop = 1'b0;
        check_val("blob3_words", 32'(n_words), 32'd24);
        check_val("blob3_eop_cnt", 32'(eop_cnt), 32'd1);
        check_val("blob3_eop_pos", 32'(eop_pos), 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
